pipelined_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for a power-of-two word width. It supports four shift modes (logical right, arithmetic right, logical left, rotate right) and uses a valid/ready handshake on both sides. It registers one log-rank per pipeline stage, so the datapath closes timing at wide words. It sits on the datapath wherever a variable shift must run at full clock rate with backpressure from the consumer.

---
 rtl/pipelined_shifter.sv | 164 ++++++++++++++++
 tb/tb_pipelined_shifter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: LOGWORD-stage barrel shifter with valid/ready handshake.
// Stage k applies the shift rank of distance 1<<(LOGWORD-1-k), MSB rank first.
// Optional feature macro: SHIFTER_STICKY_EN adds a sticky (OR of shifted-out
// bits) carried through the pipeline and the out_sticky port.
module pipelined_shifter #(
    parameter int LOGWORD = 5,
    localparam int WORD = 1 << LOGWORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD-1:0]    in_value,
    input  logic [LOGWORD-1:0] in_amount,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD-1:0]    out_value
`ifdef SHIFTER_STICKY_EN
    ,
    output logic               out_sticky
`endif
);

    localparam int LAST = LOGWORD - 1;

    typedef logic [WORD-1:0] word_t;

    // Stage registers
    logic [LAST:0]                     st_valid;
    logic [LAST:0][WORD-1:0]           st_value;
    logic [LAST:0][LOGWORD-1:0]        st_amount;
    logic [LAST:0][1:0]                st_mode;
    logic [LAST:0]                     st_sign;

    // Per-stage inputs (from in_* for stage 0, from the previous stage otherwise)
    logic [LAST:0]                     src_valid;
    logic [LAST:0][WORD-1:0]           src_value;
    logic [LAST:0][LOGWORD-1:0]        src_amount;
    logic [LAST:0][1:0]                src_mode;
    logic [LAST:0]                     src_sign;

    // Per-stage rank results and load enables
    logic [LAST:0][WORD-1:0]           nx_value;
    logic [LAST:0]                     can_load;

`ifdef SHIFTER_STICKY_EN
    logic [LAST:0]                     st_sticky;
    logic [LAST:0]                     src_sticky;
    logic [LAST:0]                     nx_sticky;
`endif

    // Control fields of the last stage and already-consumed amount bits are
    // not needed downstream; fold them into one sink so they read as used.
    logic unused_ctl;
    assign unused_ctl = ^{st_amount, st_mode, st_sign};

    // One rank of the shifter: shift v by d according to mode m.
    function automatic word_t rank_shift(word_t v, logic [1:0] m, logic s, int d);
        word_t r;
        case (m)
            2'b00:   r = v >> d;
            2'b01:   r = (v >> d) | ({WORD{s}} << (WORD - d));
            2'b10:   r = v << d;
            default: r = (v >> d) | (v << (WORD - d));
        endcase
        return r;
    endfunction

`ifdef SHIFTER_STICKY_EN
    // Bits that a right shift by d pushes off the bottom of v.
    function automatic logic rank_drop(word_t v, int d);
        return |(v & ((word_t'(1) << d) - word_t'(1)));
    endfunction
`endif

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        can_load = '0;
        can_load[LAST] = !st_valid[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            can_load[k] = !st_valid[k] || can_load[k+1];
        end
    end

    // Route each stage's source: stage 0 from the input port, others from k-1.
    always_comb begin
        src_valid     = '0;
        src_value     = '0;
        src_amount    = '0;
        src_mode      = '0;
        src_sign      = '0;
        src_valid[0]  = in_valid;
        src_value[0]  = in_value;
        src_amount[0] = in_amount;
        src_mode[0]   = in_mode;
        src_sign[0]   = in_value[WORD-1];
        for (int k = 1; k <= LAST; k++) begin
            src_valid[k]  = st_valid[k-1];
            src_value[k]  = st_value[k-1];
            src_amount[k] = st_amount[k-1];
            src_mode[k]   = st_mode[k-1];
            src_sign[k]   = st_sign[k-1];
        end
`ifdef SHIFTER_STICKY_EN
        src_sticky    = '0;
        for (int k = 1; k <= LAST; k++) begin
            src_sticky[k] = st_sticky[k-1];
        end
`endif
    end

    // Apply this stage's rank when its amount bit is set; otherwise pass through.
    always_comb begin
        nx_value = src_value;
`ifdef SHIFTER_STICKY_EN
        nx_sticky = src_sticky;
`endif
        for (int k = 0; k <= LAST; k++) begin
            if (src_amount[k][LAST-k]) begin
                nx_value[k] = rank_shift(src_value[k], src_mode[k], src_sign[k], 1 << (LAST - k));
`ifdef SHIFTER_STICKY_EN
                nx_sticky[k] = src_sticky[k] |
                               (!src_mode[k][1] && rank_drop(src_value[k], 1 << (LAST - k)));
`endif
            end
        end
    end

    // Pipeline registers: each stage loads from its source whenever it can.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid  <= '0;
            st_value  <= '0;
            st_amount <= '0;
            st_mode   <= '0;
            st_sign   <= '0;
`ifdef SHIFTER_STICKY_EN
            st_sticky <= '0;
`endif
        end else begin
            for (int k = 0; k <= LAST; k++) begin
                if (can_load[k]) begin
                    st_valid[k]  <= src_valid[k];
                    st_value[k]  <= nx_value[k];
                    st_amount[k] <= src_amount[k];
                    st_mode[k]   <= src_mode[k];
                    st_sign[k]   <= src_sign[k];
`ifdef SHIFTER_STICKY_EN
                    st_sticky[k] <= nx_sticky[k];
`endif
                end
            end
        end
    end

    assign in_ready  = can_load[0];
    assign out_valid = st_valid[LAST];
    assign out_value = st_value[LAST];
`ifdef SHIFTER_STICKY_EN
    assign out_sticky = st_sticky[LAST];
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard testbench for pipelined_shifter at LOGWORD=3 (WORD=8).
// Expected results come from a whole-amount arithmetic model of each mode.
module tb_pipelined_shifter;

    localparam int LOGWORD = 3;
    localparam int WORD    = 8;
    localparam int LAT     = LOGWORD - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_value = '0;
    logic [2:0]   in_amount = '0;
    logic [1:0]   in_mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_value;
`ifdef SHIFTER_STICKY_EN
    logic         out_sticky;
`endif

    typedef struct {
        logic [7:0] value;
        logic       sticky;
        int         acc;
        bit         strict;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails = 0;
    int   cycle = 0;
    int   pushCount = 0;
    int   outCount = 0;
    bit   strictLat = 1'b1;
    bit   randReady = 1'b0;

    pipelined_shifter #(.LOGWORD(LOGWORD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_amount (in_amount),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value)
`ifdef SHIFTER_STICKY_EN
        ,
        .out_sticky(out_sticky)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: shift the whole amount at once with plain arithmetic.
    function automatic exp_t refModel(logic [7:0] v, logic [2:0] a, logic [1:0] m);
        exp_t e;
        int full;
        int mask;
        logic signed [7:0] sv;
        full = int'(v);
        mask = (1 << a) - 1;
        sv = v;
        e.sticky = 1'b0;
        e.acc = 0;
        e.strict = 1'b0;
        case (m)
            2'b00: begin e.value = 8'(full >> a); e.sticky = (full & mask) != 0; end
            2'b01: begin e.value = sv >>> a;      e.sticky = (full & mask) != 0; end
            2'b10: e.value = 8'(full << a);
            default: e.value = 8'((full >> a) | (full << (WORD - a)));
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic pushExpected(input logic [7:0] v, input logic [2:0] a, input logic [1:0] m);
        exp_t e;
        e = refModel(v, a, m);
        e.acc = cycle + 1;
        e.strict = strictLat;
        sbq.push_back(e);
        pushCount++;
    endtask

    // Present one transaction and hold it until accepted (bounded wait).
    task automatic applyStimulus(input logic [7:0] v, input logic [2:0] a, input logic [1:0] m);
        int waited;
        bit done;
        waited = 0;
        done = 1'b0;
        @(negedge clk);
        if (randReady) out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        in_value = v;
        in_amount = a;
        in_mode = m;
        while (!done) begin
            #1;
            if (in_ready) begin
                pushExpected(v, a, m);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checkOutput("accept timeout", 32'(in_ready), 1);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    if (randReady) out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        in_valid = 1'b0;
        if (randReady) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        checkOutput("drain empty", 32'(sbq.size()), 0);
    endtask

    // Monitor: pop and compare every output transfer; check stall stability.
    initial begin
        bit prevStall;
        logic [7:0] prevVal;
        exp_t e;
        prevStall = 1'b0;
        prevVal = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prevStall = 1'b0;
                continue;
            end
            if (prevStall) begin
                checkOutput("stall valid hold", 32'(out_valid), 1);
                checkOutput("stall value hold", 32'(out_value), 32'(prevVal));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected output", 32'(out_valid), 0);
                end else begin
                    e = sbq.pop_front();
                    outCount++;
                    checkOutput("result value", 32'(out_value), 32'(e.value));
`ifdef SHIFTER_STICKY_EN
                    checkOutput("result sticky", 32'(out_sticky), 32'(e.sticky));
`endif
                    if (e.strict) checkOutput("latency", 32'(cycle - e.acc), LAT);
                    else          checkOutput("min latency", 32'(cycle - e.acc >= LAT), 1);
                end
            end
            prevStall = out_valid && !out_ready;
            prevVal = out_value;
        end
    end

    // Directed scenarios followed by a randomized backpressure run.
    initial begin
        int accepted;
        int discarded;
        logic [7:0] rv;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 0);
        checkOutput("reset out_value", 32'(out_value), 0);
        checkOutput("reset in_ready", 32'(in_ready), 1);
`ifdef SHIFTER_STICKY_EN
        checkOutput("reset out_sticky", 32'(out_sticky), 0);
`endif
        #2 rst_n = 1'b1;
        out_ready = 1'b1;

        $display("[TB] mode sweep");
        for (int m = 0; m < 4; m++) applyStimulus(8'hB4, 3'd3, 2'(m));
        drain();

        $display("[TB] zero amount");
        for (int m = 0; m < 4; m++) applyStimulus(8'h81, 3'd0, 2'(m));
        drain();

        $display("[TB] back-to-back");
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 3'd1, 2'b10);
        drain();

        $display("[TB] backpressure");
        strictLat = 1'b0;
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            rv = 8'($urandom);
            in_valid = 1'b1;
            in_value = rv;
            in_amount = 3'd2;
            in_mode = 2'b01;
            #1;
            if (in_ready) begin
                pushExpected(rv, 3'd2, 2'b01);
                accepted++;
            end
        end
        checkOutput("capacity accepts", 32'(accepted), LOGWORD);
        checkOutput("full in_ready", 32'(in_ready), 0);
        @(negedge clk);
        out_ready = 1'b1;
        rv = 8'($urandom);
        in_value = rv;
        in_amount = 3'd5;
        in_mode = 2'b11;
        #1;
        checkOutput("restart in_ready", 32'(in_ready), 1);
        if (in_ready) pushExpected(rv, 3'd5, 2'b11);
        drain();

        $display("[TB] random traffic");
        randReady = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) idleCycle();
            applyStimulus(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        randReady = 1'b0;
        drain();

        $display("[TB] reset mid-flight");
        strictLat = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(8'h55 + 8'(i), 3'd1, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("pre-reset full", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid reset out_valid", 32'(out_valid), 0);
        checkOutput("mid reset out_value", 32'(out_value), 0);
        checkOutput("mid reset in_ready", 32'(in_ready), 1);
        discarded = sbq.size();
        sbq.delete();
        pushCount -= discarded;
        @(negedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(8'h80, 3'd7, 2'b01);
        drain();

        checkOutput("output count", 32'(outCount), 32'(pushCount));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
